// File: rtl/fsm_bit_deserializer_if.sv
// fsm_bit_deserializer_if
//   Serial input and word output handshake bundle for fsm_bit_deserializer.
//   din/din_valid  : qualified serial bit from the upstream FSM.
//   dout/dout_valid/dout_ready : assembled word with a valid/ready handshake.
//   master : producer/consumer side (drives din, din_valid, dout_ready).
//   slave  : the deserializer (drives dout, dout_valid).
interface fsm_bit_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             din;
    logic             din_valid;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    modport master (
        output din,
        output din_valid,
        output dout_ready,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  din,
        input  din_valid,
        input  dout_ready,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/fsm_bit_deserializer.sv
// fsm_bit_deserializer
//   Packs qualified serial bits into WIDTH-bit words. One word can sit in the
//   shift register while another waits in the output register, so the serial
//   side never needs backpressure; bits arriving while both are full are
//   dropped and flagged on the sticky overflow output.
// Ports:
//   clk          : system clock, posedge.
//   rst          : synchronous active-low reset.
//   bus          : slave modport (din, din_valid, dout_ready in; dout, dout_valid out).
//   overflow_clr : clears overflow (a simultaneous drop wins).
//   overflow     : sticky, at least one bit was dropped.
//   bit_cnt      : bits collected in the current word.
//   state        : present FSM state (IDLE=0, SHIFT=1, STALL=2).
module fsm_bit_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    fsm_bit_deserializer_if.slave    bus,
    input  logic                     overflow_clr,
    output logic                     overflow,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic [1:0]               state
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        STALL = 2'b10,
        BAD   = 2'b11
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fresh;
    logic             handshake;
    logic             out_free;
    logic             last_bit;

    always_comb begin
        handshake = bus.dout_valid && bus.dout_ready;
        out_free  = !bus.dout_valid || handshake;
        last_bit  = (bit_cnt == LAST_CNT);
        // shifted: sr with din appended; fresh: din as the first bit of an empty word
        if (MSB_FIRST) begin
            shifted = {sr[WIDTH-2:0], bus.din};
            fresh   = {{(WIDTH-1){1'b0}}, bus.din};
        end else begin
            shifted = {bus.din, sr[WIDTH-1:1]};
            fresh   = {bus.din, {(WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st             <= IDLE;
            bit_cnt        <= '0;
            sr             <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            // Consumed word empties the output register unless a load below refills it.
            if (handshake) begin
                bus.dout_valid <= 1'b0;
            end
            if (overflow_clr) begin
                overflow <= 1'b0;
            end

            case (st)
                IDLE: begin
                    if (bus.din_valid) begin
                        sr      <= shifted;
                        bit_cnt <= bit_cnt + 1'b1;
                        st      <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bus.din_valid) begin
                        if (!last_bit) begin
                            sr      <= shifted;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (out_free) begin
                            bus.dout       <= shifted;
                            bus.dout_valid <= 1'b1;
                            sr             <= '0;
                            bit_cnt        <= '0;
                            st             <= IDLE;
                        end else begin
                            sr      <= shifted;
                            bit_cnt <= '0;
                            st      <= STALL;
                        end
                    end
                end

                STALL: begin
                    if (handshake) begin
                        bus.dout       <= sr;
                        bus.dout_valid <= 1'b1;
                        if (bus.din_valid) begin
                            sr      <= fresh;
                            bit_cnt <= CW'(1);
                            st      <= SHIFT;
                        end else begin
                            sr <= '0;
                            st <= IDLE;
                        end
                    end else if (bus.din_valid) begin
                        // Overrides a same-edge overflow_clr.
                        overflow <= 1'b1;
                    end
                end

                default: begin
                    st      <= IDLE;
                    bit_cnt <= '0;
                    sr      <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state = st;
    end
endmodule

// File: tb/tb_fsm_bit_deserializer.sv
// tb_fsm_bit_deserializer
//   Directed bench: two instances (MSB-first and LSB-first) share stimulus;
//   expected words are hand-computed constants.
module tb_fsm_bit_deserializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       dout_ready = 1'b0;
    logic       overflow_clr = 1'b0;

    logic       ovf_msb, ovf_lsb;
    logic [2:0] cnt_msb, cnt_lsb;
    logic [1:0] st_msb, st_lsb;

    int unsigned tests = 0;
    int unsigned fails = 0;

    bit         mon_en = 1'b0;
    logic [7:0] got[$];

    fsm_bit_deserializer_if #(.WIDTH(8)) bus_msb ();
    fsm_bit_deserializer_if #(.WIDTH(8)) bus_lsb ();

    assign bus_msb.din        = din;
    assign bus_msb.din_valid  = din_valid;
    assign bus_msb.dout_ready = dout_ready;
    assign bus_lsb.din        = din;
    assign bus_lsb.din_valid  = din_valid;
    assign bus_lsb.dout_ready = dout_ready;

    fsm_bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_msb),
        .overflow_clr (overflow_clr),
        .overflow     (ovf_msb),
        .bit_cnt      (cnt_msb),
        .state        (st_msb)
    );

    fsm_bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_lsb),
        .overflow_clr (overflow_clr),
        .overflow     (ovf_lsb),
        .bit_cnt      (cnt_lsb),
        .state        (st_lsb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Records any handshake happening at the coming edge, then moves past it.
    task automatic tick();
        if (mon_en && bus_msb.dout_valid && dout_ready) got.push_back(bus_msb.dout);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din       = 1'bx;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic [7:0] exp_w [3];
        exp_w = '{8'hA5, 8'hC3, 8'h96};

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check_eq("rst_state", st_msb, 2'd0);
        check_eq("rst_cnt", cnt_msb, 3'd0);
        check_eq("rst_dout", bus_msb.dout, 8'h00);
        check_eq("rst_valid", bus_msb.dout_valid, 1'b0);
        check_eq("rst_ovf", ovf_msb, 1'b0);
        rst = 1'b1;
        tick();

        // Basic word, ready high; MSB-first B2, LSB-first 4D
        dout_ready = 1'b1;
        w = 8'hB2;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        check_eq("b2_pre_valid", bus_msb.dout_valid, 1'b0);
        check_eq("b2_pre_cnt", cnt_msb, 3'd7);
        check_eq("b2_pre_state", st_msb, 2'd1);
        send_bit(w[0]);
        check_eq("b2_valid", bus_msb.dout_valid, 1'b1);
        check_eq("b2_dout", bus_msb.dout, 8'hB2);
        check_eq("lsb_dout", bus_lsb.dout, 8'h4D);
        check_eq("lsb_valid", bus_lsb.dout_valid, 1'b1);
        check_eq("b2_state", st_msb, 2'd0);
        check_eq("b2_cnt", cnt_msb, 3'd0);
        tick();
        check_eq("b2_one_cycle", bus_msb.dout_valid, 1'b0);

        // Back-to-back words with no consumer: second word stalls
        dout_ready = 1'b0;
        send_word(8'hB2);
        check_eq("bb_first_valid", bus_msb.dout_valid, 1'b1);
        check_eq("bb_first_dout", bus_msb.dout, 8'hB2);
        send_word(8'h5A);
        check_eq("bb_stall_state", st_msb, 2'd2);
        check_eq("bb_hold_dout", bus_msb.dout, 8'hB2);
        check_eq("bb_stall_cnt", cnt_msb, 3'd0);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check_eq("bb_drain_dout", bus_msb.dout, 8'h5A);
        check_eq("bb_drain_valid", bus_msb.dout_valid, 1'b1);
        check_eq("bb_drain_state", st_msb, 2'd0);
        check_eq("bb_ovf", ovf_msb, 1'b0);
        dout_ready = 1'b1;
        tick();
        check_eq("bb_empty", bus_msb.dout_valid, 1'b0);

        // 17 bits with no consumer: 17th dropped
        dout_ready = 1'b0;
        send_word(8'hB2);
        send_word(8'h5A);
        check_eq("ov_pre", ovf_msb, 1'b0);
        send_bit(1'b1);
        check_eq("ov_set", ovf_msb, 1'b1);
        check_eq("ov_state", st_msb, 2'd2);
        check_eq("ov_dout_b2", bus_msb.dout, 8'hB2);
        dout_ready = 1'b1;
        tick();
        check_eq("ov_dout_5a", bus_msb.dout, 8'h5A);
        check_eq("ov_drain_state", st_msb, 2'd0);
        check_eq("ov_drain_cnt", cnt_msb, 3'd0);
        tick();
        check_eq("ov_empty", bus_msb.dout_valid, 1'b0);
        check_eq("ov_sticky", ovf_msb, 1'b1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("ov_clr", ovf_msb, 1'b0);

        // Reset mid-word
        w = 8'hFF;
        for (int i = 0; i < 5; i++) send_bit(w[i]);
        check_eq("mid_cnt", cnt_msb, 3'd5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("mid_rst_cnt", cnt_msb, 3'd0);
        check_eq("mid_rst_valid", bus_msb.dout_valid, 1'b0);
        check_eq("mid_rst_state", st_msb, 2'd0);
        send_word(8'h3C);
        check_eq("post_rst_dout", bus_msb.dout, 8'h3C);
        check_eq("post_rst_valid", bus_msb.dout_valid, 1'b1);
        tick();

        // Gapped bits, last-bit completion coincides with a handshake
        got.delete();
        mon_en = 1'b1;
        dout_ready = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick();
            tick();
            send_bit(exp_w[0][i]);
        end
        check_eq("gap_w1", bus_msb.dout, 8'hA5);
        for (int i = 7; i >= 0; i--) begin
            tick();
            tick();
            dout_ready = (i == 0);
            send_bit(exp_w[1][i]);
            dout_ready = 1'b0;
        end
        check_eq("gap_nobubble_valid", bus_msb.dout_valid, 1'b1);
        check_eq("gap_nobubble_dout", bus_msb.dout, 8'hC3);
        check_eq("gap_state", st_msb, 2'd0);
        for (int i = 7; i >= 0; i--) begin
            dout_ready = ~dout_ready;
            tick();
            dout_ready = ~dout_ready;
            tick();
            dout_ready = ~dout_ready;
            send_bit(exp_w[2][i]);
        end
        dout_ready = 1'b1;
        tick();
        mon_en = 1'b0;
        check_eq("gap_count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("gap_word%0d", i),
                     (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, exp_w[i]});
        end
        check_eq("gap_ovf", ovf_msb, 1'b0);
        check_eq("gap_final_valid", bus_msb.dout_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
